// File: rtl/timing_io_gen_pkg.sv
// Shared definitions for the timing/IO generator: subcycle encoding, clock-phase
// indices and the legal parameter ranges.
package timing_io_gen_pkg;

  typedef enum logic [2:0] {
    SC_A1 = 3'd0,
    SC_A2 = 3'd1,
    SC_A3 = 3'd2,
    SC_M1 = 3'd3,
    SC_M2 = 3'd4,
    SC_X1 = 3'd5,
    SC_X2 = 3'd6,
    SC_X3 = 3'd7
  } subcycle_e;

  localparam logic [1:0] PH_CLK1 = 2'd0;
  localparam logic [1:0] PH_GAP1 = 2'd1;
  localparam logic [1:0] PH_CLK2 = 2'd2;
  localparam logic [1:0] PH_GAP2 = 2'd3;

  localparam int DATA_W_MIN  = 4;
  localparam int DATA_W_MAX  = 16;
  localparam int PH_LEN_MIN  = 1;
  localparam int PH_LEN_MAX  = 16;
  localparam int N_CMRAM_MIN = 1;
  localparam int N_CMRAM_MAX = 8;
  localparam int POC_CYC_MIN = 1;
  localparam int POC_CYC_MAX = 15;

  function automatic logic [7:0] sc_onehot(input subcycle_e s);
    return 8'd1 << s;
  endfunction

endpackage

// File: rtl/timing_io_gen_if.sv
// Processor-side bus of the timing/IO generator: instruction flags, address/data,
// pad pins, captured nibbles with their strobes, and CM-RAM lines.
interface timing_io_gen_if #(
  parameter int DATA_W  = 4,
  parameter int N_CMRAM = 4
) ();
  logic                  ior;
  logic                  iow;
  logic [3*DATA_W-1:0]   addr;
  logic [DATA_W-1:0]     wr_data;
  logic [N_CMRAM-1:0]    cm_en;
  logic [DATA_W-1:0]     data_pad_i;
  logic [DATA_W-1:0]     data_pad_o;
  logic                  data_oe;
  logic [DATA_W-1:0]     opr;
  logic [DATA_W-1:0]     opa;
  logic [DATA_W-1:0]     opx;
  logic                  op_valid;
  logic                  x_valid;
  logic [N_CMRAM-1:0]    cm_pad;

  modport master (
    output ior, iow, addr, wr_data, cm_en, data_pad_i,
    input  data_pad_o, data_oe, opr, opa, opx, op_valid, x_valid, cm_pad
  );

  modport slave (
    input  ior, iow, addr, wr_data, cm_en, data_pad_i,
    output data_pad_o, data_oe, opr, opa, opx, op_valid, x_valid, cm_pad
  );
endinterface

// File: rtl/timing_io_gen_seq.sv
// Two-phase clock and subcycle sequencer. Outputs are registered from the decode of
// the next position so clk1/clk2/phase/sync all change on the same sysclk edge.
module timing_io_gen_seq
  import timing_io_gen_pkg::*;
#(
  parameter int PH_LEN = 2
) (
  input  logic       sysclk,
  input  logic       poc_n,
  output logic       clk1,
  output logic       clk2,
  output logic [7:0] phase,
  output logic       sync,
  output subcycle_e  cur_sc,
  output subcycle_e  next_sc,
  output logic       sc_start,
  output logic       cap_edge,
  output logic       cycle_wrap
);

  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;
  logic [1:0] ph_r;
  logic [1:0] ph_nxt_s;
  subcycle_e  sc_r;
  subcycle_e  sc_nxt_s;
  logic       started_r;
  logic       last_s;

  assign last_s = (cnt_r == 4'(PH_LEN - 1));

  // Next position; the first sysclk after reset presents A1/ph0 itself
  always_comb begin
    cnt_nxt_s = cnt_r;
    ph_nxt_s  = ph_r;
    sc_nxt_s  = sc_r;
    if (!started_r) begin
      cnt_nxt_s = 4'd0;
      ph_nxt_s  = PH_CLK1;
      sc_nxt_s  = SC_A1;
    end else if (!last_s) begin
      cnt_nxt_s = cnt_r + 4'd1;
    end else begin
      cnt_nxt_s = 4'd0;
      ph_nxt_s  = ph_r + 2'd1;
      if (ph_r == PH_GAP2) begin
        sc_nxt_s = subcycle_e'(sc_r + 3'd1);
      end else begin
        sc_nxt_s = sc_r;
      end
    end
  end

  assign cur_sc     = sc_r;
  assign next_sc    = sc_nxt_s;
  assign sc_start   = (cnt_nxt_s == 4'd0) && (ph_nxt_s == PH_CLK1);
  assign cap_edge   = started_r && (ph_r == PH_CLK2) && last_s;
  assign cycle_wrap = started_r && sc_start && (sc_nxt_s == SC_A1);

  // Position counters and registered clock/phase outputs
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      cnt_r     <= 4'd0;
      ph_r      <= PH_CLK1;
      sc_r      <= SC_A1;
      started_r <= 1'b0;
      clk1      <= 1'b0;
      clk2      <= 1'b0;
      phase     <= sc_onehot(SC_A1);
      sync      <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      ph_r      <= ph_nxt_s;
      sc_r      <= sc_nxt_s;
      started_r <= 1'b1;
      clk1      <= (ph_nxt_s == PH_CLK1);
      clk2      <= (ph_nxt_s == PH_CLK2);
      phase     <= sc_onehot(sc_nxt_s);
      sync      <= (sc_nxt_s == SC_X3);
    end
  end

endmodule

// File: rtl/timing_io_gen.sv
// Timing and I/O generator top: pad drive, operand capture, CM-RAM selects,
// power-on-clear and TEST synchronisation around the clock sequencer.
module timing_io_gen
  import timing_io_gen_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int PH_LEN  = 2,
  parameter int N_CMRAM = 4,
  parameter int POC_CYC = 2
) (
  input  logic           sysclk,
  input  logic           poc_n,
  input  logic           test_pad,
  output logic           clk1,
  output logic           clk2,
  output logic [7:0]     phase,
  output logic           sync,
  output logic           poc,
  output logic           test_n,
  timing_io_gen_if.slave bus
);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX ||
      PH_LEN < PH_LEN_MIN || PH_LEN > PH_LEN_MAX ||
      N_CMRAM < N_CMRAM_MIN || N_CMRAM > N_CMRAM_MAX ||
      POC_CYC < POC_CYC_MIN || POC_CYC > POC_CYC_MAX) begin : g_bad_cfg
    $error("timing_io_gen: parameter outside legal range");
  end

  subcycle_e          cur_sc_s;
  subcycle_e          next_sc_s;
  logic               sc_start_s;
  logic               cap_edge_s;
  logic               cycle_wrap_s;

  logic               poc_r;
  logic               poc_nxt_s;
  logic [3:0]         poc_cyc_r;
  logic               oe_r;
  logic               oe_nxt_s;
  logic [DATA_W-1:0]  pad_o_r;
  logic [DATA_W-1:0]  pad_nxt_s;
  logic [N_CMRAM-1:0] cm_r;
  logic [N_CMRAM-1:0] cm_nxt_s;
  logic [DATA_W-1:0]  opr_r;
  logic [DATA_W-1:0]  opa_r;
  logic [DATA_W-1:0]  opx_r;
  logic               op_valid_r;
  logic               x_valid_r;
  logic               test_meta_r;
  logic               test_n_r;

  timing_io_gen_seq #(.PH_LEN(PH_LEN)) u_seq (
    .sysclk     (sysclk),
    .poc_n      (poc_n),
    .clk1       (clk1),
    .clk2       (clk2),
    .phase      (phase),
    .sync       (sync),
    .cur_sc     (cur_sc_s),
    .next_sc    (next_sc_s),
    .sc_start   (sc_start_s),
    .cap_edge   (cap_edge_s),
    .cycle_wrap (cycle_wrap_s)
  );

  // poc drops on the A1 edge that completes the POC_CYC-th instruction cycle
  always_comb begin
    if (poc_r && cycle_wrap_s && (poc_cyc_r == 4'(POC_CYC - 1))) begin
      poc_nxt_s = 1'b0;
    end else begin
      poc_nxt_s = poc_r;
    end
  end

  // Pad and CM-RAM values for the subcycle about to start
  always_comb begin
    oe_nxt_s  = 1'b0;
    pad_nxt_s = {DATA_W{1'b0}};
    cm_nxt_s  = {N_CMRAM{1'b0}};
    if (poc_nxt_s) begin
      oe_nxt_s  = 1'b0;
      pad_nxt_s = {DATA_W{1'b0}};
      cm_nxt_s  = {N_CMRAM{1'b0}};
    end else begin
      case (next_sc_s)
        SC_A1: begin
          oe_nxt_s  = 1'b1;
          pad_nxt_s = bus.addr[0 +: DATA_W];
        end
        SC_A2: begin
          oe_nxt_s  = 1'b1;
          pad_nxt_s = bus.addr[DATA_W +: DATA_W];
        end
        SC_A3: begin
          oe_nxt_s  = 1'b1;
          pad_nxt_s = bus.addr[2*DATA_W +: DATA_W];
          cm_nxt_s  = bus.cm_en;
        end
        SC_X2: begin
          oe_nxt_s  = bus.iow;
          pad_nxt_s = bus.iow ? bus.wr_data : {DATA_W{1'b0}};
          cm_nxt_s  = (bus.ior || bus.iow) ? bus.cm_en : {N_CMRAM{1'b0}};
        end
        default: begin
          oe_nxt_s  = 1'b0;
          pad_nxt_s = {DATA_W{1'b0}};
          cm_nxt_s  = {N_CMRAM{1'b0}};
        end
      endcase
    end
  end

  // POC state, subcycle-aligned pad/CM registers and operand captures
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      poc_r      <= 1'b1;
      poc_cyc_r  <= 4'd0;
      oe_r       <= 1'b0;
      pad_o_r    <= {DATA_W{1'b0}};
      cm_r       <= {N_CMRAM{1'b0}};
      opr_r      <= {DATA_W{1'b0}};
      opa_r      <= {DATA_W{1'b0}};
      opx_r      <= {DATA_W{1'b0}};
      op_valid_r <= 1'b0;
      x_valid_r  <= 1'b0;
    end else begin
      poc_r <= poc_nxt_s;
      if (poc_r && cycle_wrap_s) begin
        poc_cyc_r <= poc_cyc_r + 4'd1;
      end
      if (sc_start_s) begin
        oe_r    <= oe_nxt_s;
        pad_o_r <= pad_nxt_s;
        cm_r    <= cm_nxt_s;
      end
      op_valid_r <= 1'b0;
      x_valid_r  <= 1'b0;
      if (cap_edge_s && !poc_r) begin
        case (cur_sc_s)
          SC_M1: opr_r <= bus.data_pad_i;
          SC_M2: begin
            opa_r      <= bus.data_pad_i;
            op_valid_r <= 1'b1;
          end
          SC_X2: begin
            // a simultaneous write owns the bus, so the read is dropped
            if (bus.ior && !bus.iow) begin
              opx_r     <= bus.data_pad_i;
              x_valid_r <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Two-flop synchroniser for the raw TEST pin, idles at "not asserted"
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      test_meta_r <= 1'b1;
      test_n_r    <= 1'b1;
    end else begin
      test_meta_r <= ~test_pad;
      test_n_r    <= test_meta_r;
    end
  end

  assign poc            = poc_r;
  assign test_n         = test_n_r;
  assign bus.data_oe    = oe_r;
  assign bus.data_pad_o = pad_o_r;
  assign bus.cm_pad     = cm_r;
  assign bus.opr        = opr_r;
  assign bus.opa        = opa_r;
  assign bus.opx        = opx_r;
  assign bus.op_valid   = op_valid_r;
  assign bus.x_valid    = x_valid_r;

endmodule

// File: tb/tb_timing_io_gen.sv
// Bench for timing_io_gen (PH_LEN=1, POC_CYC=2): per-sysclk timing/pad checks plus
// a scoreboard of capture results popped on op_valid / x_valid.
module tb_timing_io_gen;

  logic       sysclk = 1'b0;
  logic       poc_n  = 1'b0;
  logic       test_pad = 1'b0;
  logic       clk1, clk2, sync, poc, test_n;
  logic [7:0] phase;

  int errors = 0;
  int checks = 0;

  timing_io_gen_if #(.DATA_W(4), .N_CMRAM(4)) bus ();

  timing_io_gen #(.DATA_W(4), .PH_LEN(1), .N_CMRAM(4), .POC_CYC(2)) dut (
    .sysclk   (sysclk),
    .poc_n    (poc_n),
    .test_pad (test_pad),
    .clk1     (clk1),
    .clk2     (clk2),
    .phase    (phase),
    .sync     (sync),
    .poc      (poc),
    .test_n   (test_n),
    .bus      (bus)
  );

  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic [11:0] addr;
    logic        ior;
    logic        iow;
    logic [3:0]  wr;
    logic [3:0]  cm;
    logic [3:0]  p_m1;
    logic [3:0]  p_m2;
    logic [3:0]  p_x2;
    logic        exp_op;
    logic [3:0]  e_opr;
    logic [3:0]  e_opa;
    logic        exp_x;
    logic [3:0]  e_opx;
  } vec_t;

  vec_t       vt [0:10];
  logic [7:0] op_q [$];
  logic [3:0] x_q [$];
  int         cur_v = -1;
  logic       prev_op = 1'b0;
  logic       prev_x = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic tp_at(input int ep, input int k);
    return (ep == 0) && (k >= 40) && (k < 50);
  endfunction

  task automatic apply_vec(input int v);
    bus.addr    = vt[v].addr;
    bus.ior     = vt[v].ior;
    bus.iow     = vt[v].iow;
    bus.wr_data = vt[v].wr;
    bus.cm_en   = vt[v].cm;
    if (v != cur_v) begin
      cur_v = v;
      if (vt[v].exp_op) op_q.push_back({vt[v].e_opr, vt[v].e_opa});
      if (vt[v].exp_x)  x_q.push_back(vt[v].e_opx);
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, {4'd0, clk1, clk2, sync, poc, test_n, bus.data_oe, bus.data_pad_o, bus.cm_pad,
               bus.opr, bus.opa, bus.opx, bus.op_valid, bus.x_valid},
        {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0});
  endtask

  task automatic chk_cycle(input int ep, input int base, input int k);
    int         v  = base + k / 32;
    int         ph = k % 4;
    int         sc = (k / 4) % 8;
    logic       p  = (k < 64);
    logic       e_oe;
    logic [3:0] e_pad, e_cm;
    logic [11:0] a;
    a     = vt[v].addr;
    e_oe  = 1'b0;
    e_pad = 4'h0;
    e_cm  = 4'h0;
    if (!p) begin
      if (sc <= 2) begin
        e_oe  = 1'b1;
        e_pad = a[sc*4 +: 4];
      end
      if (sc == 6 && vt[v].iow) begin
        e_oe  = 1'b1;
        e_pad = vt[v].wr;
      end
      if (sc == 2 || (sc == 6 && (vt[v].ior || vt[v].iow))) e_cm = vt[v].cm;
    end
    chk($sformatf("timing ep=%0d k=%0d", ep, k),
        {19'd0, clk1, clk2, sync, poc, test_n, phase},
        {19'd0, ph == 0, ph == 2, sc == 7, p, ~tp_at(ep, k - 2), 8'd1 << sc});
    chk($sformatf("pad ep=%0d k=%0d", ep, k),
        {23'd0, bus.data_oe, bus.data_pad_o, bus.cm_pad},
        {23'd0, e_oe, e_pad, e_cm});
  endtask

  task automatic run_epoch(input int ep, input int base, input int last_k);
    int v, sc;
    for (int k = 0; k <= last_k; k++) begin
      @(negedge sysclk);
      chk_cycle(ep, base, k);
      if (k != last_k) begin
        apply_vec(base + (k + 1) / 32);
        v  = base + k / 32;
        sc = (k / 4) % 8;
        bus.data_pad_i = (sc == 3) ? vt[v].p_m1 : (sc == 4) ? vt[v].p_m2 :
                         (sc == 6) ? vt[v].p_x2 : 4'h0;
        test_pad = tp_at(ep, k);
      end
    end
  endtask

  // Scoreboard monitor: compares captured nibbles whenever a strobe is seen
  initial begin
    forever begin
      @(negedge sysclk);
      if (bus.op_valid) begin
        chk("op_valid single pulse", {31'd0, prev_op}, 32'd0);
        chk("op_valid expected", 32'(op_q.size() != 0), 32'd1);
        if (op_q.size() != 0) chk("opr/opa", {24'd0, bus.opr, bus.opa}, {24'd0, op_q.pop_front()});
      end
      if (bus.x_valid) begin
        chk("x_valid single pulse", {31'd0, prev_x}, 32'd0);
        chk("x_valid expected", 32'(x_q.size() != 0), 32'd1);
        if (x_q.size() != 0) chk("opx", {28'd0, bus.opx}, {28'd0, x_q.pop_front()});
      end
      prev_op = bus.op_valid;
      prev_x  = bus.x_valid;
    end
  end

  initial begin
    //            addr    ior   iow   wr    cm       m1    m2    x2    op    opr   opa   x     opx
    vt[0]  = '{12'hABC, 1'b1, 1'b0, 4'h0, 4'hF, 4'h5, 4'h9, 4'h3, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0};
    vt[1]  = '{12'h5A7, 1'b0, 1'b1, 4'h6, 4'h3, 4'h1, 4'h1, 4'h1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0};
    vt[2]  = '{12'hABC, 1'b0, 1'b0, 4'h0, 4'hF, 4'h5, 4'h9, 4'h3, 1'b1, 4'h5, 4'h9, 1'b0, 4'h0};
    vt[3]  = '{12'h123, 1'b1, 1'b0, 4'h0, 4'h3, 4'h1, 4'h2, 4'h3, 1'b1, 4'h1, 4'h2, 1'b1, 4'h3};
    vt[4]  = '{12'hF0E, 1'b1, 1'b1, 4'h6, 4'h5, 4'h7, 4'h8, 4'hD, 1'b1, 4'h7, 4'h8, 1'b0, 4'h0};
    vt[5]  = '{12'h0D4, 1'b0, 1'b1, 4'hA, 4'h8, 4'h0, 4'hF, 4'hE, 1'b1, 4'h0, 4'hF, 1'b0, 4'h0};
    vt[6]  = '{12'h777, 1'b1, 1'b0, 4'h0, 4'h2, 4'h4, 4'hC, 4'h1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0};
    vt[7]  = '{12'hABC, 1'b1, 1'b1, 4'h5, 4'hF, 4'h5, 4'h5, 4'h5, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0};
    vt[8]  = '{12'h321, 1'b1, 1'b0, 4'h0, 4'h1, 4'h2, 4'h2, 4'h2, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0};
    vt[9]  = '{12'h9C3, 1'b1, 1'b0, 4'h0, 4'h6, 4'h2, 4'hB, 4'h6, 1'b1, 4'h2, 4'hB, 1'b1, 4'h6};
    vt[10] = '{12'h000, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0};

    bus.data_pad_i = 4'h0;
    apply_vec(0);
    repeat (3) @(negedge sysclk);
    chk_reset("reset state");
    poc_n = 1'b1;

    // epoch 0: stop in M2 of the seventh instruction cycle (k = 6*32+17)
    run_epoch(0, 0, 209);
    #1 poc_n = 1'b0;
    #1 chk_reset("async reset in M2");
    @(negedge sysclk);
    chk_reset("held in reset");
    bus.data_pad_i = 4'h0;
    test_pad = 1'b0;
    apply_vec(7);
    poc_n = 1'b1;

    run_epoch(1, 7, 99);
    repeat (2) @(negedge sysclk);
    chk("op queue drained", 32'(op_q.size()), 32'd0);
    chk("x queue drained", 32'(x_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
